data_memory_responder: RTL

//   Responder end of the CPU data-memory interface: decodes addressM/writeM/outM from the CPU
//   and returns inM. Backs RAM (16K words) and a screen shadow (8K words) and holds the

---
 rtl/data_memory_responder_pkg.sv | 43 ++++
 rtl/data_memory_responder_if.sv | 41 ++++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/data_memory_responder.sv | 125 ++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_responder_pkg
//   Shared constants and address decode for the CPU data-memory responder.
//   Holds the memory-map constants (screen base, keyboard address, RAM and
//   screen sizes) used by the responder and by the blocks that talk to it,
//   plus the region type and the decode helper.
// ---------------------------------------------------------------------------
package data_memory_responder_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 15;
  localparam int RAM_ADDR_W    = 14;
  localparam int SCREEN_ADDR_W = 13;

  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_WORDS = 8192;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_SCREEN,
    REGION_KBD,
    REGION_NONE
  } region_e;

  // Everything above the keyboard word is unmapped: reads give 0, writes vanish.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e r;
    if (addr < SCREEN_BASE) begin
      r = REGION_RAM;
    end else if (addr < KBD_ADDR) begin
      r = REGION_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REGION_KBD;
    end else begin
      r = REGION_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// ---------------------------------------------------------------------------
// data_memory_responder_if
//   Bundles the CPU data bus, the display write stream and the keyboard
//   front-end signals seen by the responder.
//   CPU side    : addressM, writeM, outM (to responder), inM (from responder)
//   Display side: fb_valid, fb_addr, fb_data, fb_overflow (from responder),
//                 fb_ready (to responder)
//   Keyboard    : kbd_code, kbd_press, kbd_release (to responder)
//   Modports: master = CPU/display/keyboard environment, slave = responder.
// ---------------------------------------------------------------------------
interface data_memory_responder_if #(
  parameter int FB_ADDR_W = 13
);
  import data_memory_responder_pkg::*;

  logic [ADDR_W-1:0]    addressM;
  logic                 writeM;
  logic [DATA_W-1:0]    outM;
  logic [DATA_W-1:0]    inM;

  logic                 fb_valid;
  logic                 fb_ready;
  logic [FB_ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0]    fb_data;
  logic                 fb_overflow;

  logic [DATA_W-1:0]    kbd_code;
  logic                 kbd_press;
  logic                 kbd_release;

  modport master (
    output addressM, writeM, outM, fb_ready, kbd_code, kbd_press, kbd_release,
    input  inM, fb_valid, fb_addr, fb_data, fb_overflow
  );

  modport slave (
    input  addressM, writeM, outM, fb_ready, kbd_code, kbd_press, kbd_release,
    output inM, fb_valid, fb_addr, fb_data, fb_overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO carrying screen writes toward the display.
//   Ports: clk, reset_n (async, active-low), push, pop, din -> dout (head
//   entry, combinational), full, empty.
//   DEPTH must be a power of two and at least 2. Pointers carry one extra
//   bit so full and empty can be told apart when the low bits match.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 29,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  // A push into a full FIFO is only taken when the head leaves in the same
  // edge; the slot being written is then the one being vacated.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
               (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    dout     = mem_q[rd_ptr_q[IDX_W-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// ---------------------------------------------------------------------------
// data_memory_responder
//   Responder end of the CPU data-memory interface. Decodes the CPU address,
//   returns registered read data on inM one cycle later, backs 16K words of
//   RAM and an 8K-word screen shadow, holds the keyboard register, and
//   forwards every screen write to the display through a small FIFO.
//   Ports:
//     clk      - system clock, all state changes on posedge
//     reset_n  - asynchronous active-low reset
//     bus      - data_memory_responder_if.slave (CPU bus, display stream,
//                keyboard strobes)
//   RAM and the screen shadow are never cleared and survive reset.
// ---------------------------------------------------------------------------
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int FB_FIFO_DEPTH = 4,
  parameter int FB_ADDR_W     = 13
) (
  input  logic                   clk,
  input  logic                   reset_n,
  data_memory_responder_if.slave bus
);

  localparam int FB_WIDTH = FB_ADDR_W + DATA_W;

  logic [DATA_W-1:0] ram_q    [RAM_WORDS];
  logic [DATA_W-1:0] shadow_q [SCREEN_WORDS];

  region_e                  region;
  logic                     ram_we;
  logic                     scr_we;
  logic [RAM_ADDR_W-1:0]    ram_idx;
  logic [SCREEN_ADDR_W-1:0] scr_idx;

  logic [DATA_W-1:0] inm_q, inm_d;
  logic [DATA_W-1:0] kbd_q, kbd_d;
  logic              overflow_q, overflow_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [FB_WIDTH-1:0] fifo_din;
  logic [FB_WIDTH-1:0] fifo_dout;

  // Address decode, read mux and next-state for the small registers.
  // The read mux looks at memory before this edge's write lands, so a read
  // and write of the same word in one edge returns the old word.
  always_comb begin
    region     = decode_region(bus.addressM);
    ram_idx    = bus.addressM[RAM_ADDR_W-1:0];
    scr_idx    = bus.addressM[SCREEN_ADDR_W-1:0];
    ram_we     = bus.writeM && (region == REGION_RAM);
    scr_we     = bus.writeM && (region == REGION_SCREEN);

    inm_d = '0;
    case (region)
      REGION_RAM:    inm_d = ram_q[ram_idx];
      REGION_SCREEN: inm_d = shadow_q[scr_idx];
      REGION_KBD:    inm_d = kbd_q;
      default:       inm_d = '0;
    endcase

    // Press takes priority over release when both strobe together.
    kbd_d = kbd_q;
    if (bus.kbd_press) begin
      kbd_d = bus.kbd_code;
    end else if (bus.kbd_release) begin
      kbd_d = '0;
    end

    fifo_pop  = !fifo_empty && bus.fb_ready;
    fifo_push = scr_we;
    fifo_din  = {bus.addressM[FB_ADDR_W-1:0], bus.outM};

    // A screen write is lost only when the FIFO is full and nothing leaves.
    overflow_d = overflow_q || (scr_we && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inm_q      <= '0;
      kbd_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      inm_q      <= inm_d;
      kbd_q      <= kbd_d;
      overflow_q <= overflow_d;
    end
  end

  // RAM and screen shadow have no reset so their contents persist across it.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= bus.outM;
    end
    if (scr_we) begin
      shadow_q[scr_idx] <= bus.outM;
    end
  end

  sync_fifo #(
    .WIDTH (FB_WIDTH),
    .DEPTH (FB_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The head is masked to zero while empty so the display never sees stale
  // FIFO storage and the outputs read zero straight out of reset.
  assign bus.inM         = inm_q;
  assign bus.fb_valid    = !fifo_empty;
  assign bus.fb_addr     = fifo_empty ? '0 : fifo_dout[FB_WIDTH-1:DATA_W];
  assign bus.fb_data     = fifo_empty ? '0 : fifo_dout[DATA_W-1:0];
  assign bus.fb_overflow = overflow_q;

endmodule
